sa_cache_tag: RTL

Set-associative tag array for the instruction cache, replacing the single-way, 1024-entry tag memory. It stores per-way tag, valid and dirty bits plus per-set pseudo-LRU state. Lookup, fill, invalidate and mark-dirty requests return a registered response one cycle later, including victim information for write-back. A flush state machine invalidates the whole array. It sits between the cache controller FSM and the data array, and the controller uses `rsp_way` to address the data array.

---
 rtl/sa_cache_tag_if.sv | 43 ++++
 rtl/sa_cache_tag.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_cache_tag_if.sv
// Request/response/flush bundle between the cache controller (master) and the
// set-associative tag array (slave).
interface sa_cache_tag_if #(
  parameter int WAYS  = 2,
  parameter int SETS  = 256,
  parameter int TAG_W = 18
);
  localparam int IW = $clog2(SETS);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [IW-1:0]    req_index;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_hit;
  logic [WW-1:0]    rsp_way;
  logic             rsp_dirty;
  logic             rsp_victim_valid;
  logic             rsp_victim_dirty;
  logic [TAG_W-1:0] rsp_victim_tag;

  logic             flush_start;
  logic             flush_busy;
  logic             flush_done;
  logic             parity_err;

  modport master (
    output req_valid, req_op, req_index, req_tag, flush_start,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_dirty,
           rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag,
           flush_busy, flush_done, parity_err
  );

  modport slave (
    input  req_valid, req_op, req_index, req_tag, flush_start,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_dirty,
           rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag,
           flush_busy, flush_done, parity_err
  );
endinterface

// File: rtl/sa_cache_tag.sv
// Set-associative I-cache tag array with PLRU replacement, registered responses
// and a set-per-cycle flush engine. Optional tag parity: CACHE_TAG_PARITY_EN.
module sa_cache_tag #(
  parameter int WAYS  = 2,
  parameter int SETS  = 256,
  parameter int TAG_W = 18
) (
  input  logic          clk,
  input  logic          rst,
  sa_cache_tag_if.slave bus
);
  localparam int IW = $clog2(SETS);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;
  localparam logic [1:0] OP_DIRTY  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_DONE} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] flush_idx_reg, flush_idx_next;
  logic          req_ready, flush_busy, flush_done;

  logic [WAYS-1:0]  valid_reg [SETS];
  logic [WAYS-1:0]  dirty_reg [SETS];
  logic [TAG_W-1:0] tag_reg   [SETS][WAYS];
  logic [PW-1:0]    plru_reg  [SETS];
`ifdef CACHE_TAG_PARITY_EN
  logic [WAYS-1:0]  par_reg   [SETS];
  logic             parity_err_reg;
`endif

  logic             rsp_valid_reg, rsp_hit_reg, rsp_dirty_reg;
  logic [WW-1:0]    rsp_way_reg;
  logic             rsp_victim_valid_reg, rsp_victim_dirty_reg;
  logic [TAG_W-1:0] rsp_victim_tag_reg;

  logic [WAYS-1:0]  set_valid, set_dirty;
  logic [TAG_W-1:0] set_tag [WAYS];
  logic [PW-1:0]    set_plru;
  logic [WAYS-1:0]  match_vec, par_bad_vec, hit_vec;

  logic          accept, any_hit, inv_found, do_touch;
  logic [WW-1:0] hit_way, inv_way, plru_victim, victim_way, write_way;
  logic [PW-1:0] plru_touch;

  assign accept    = bus.req_valid && req_ready;
  assign set_valid = valid_reg[bus.req_index];
  assign set_dirty = dirty_reg[bus.req_index];
  assign set_plru  = plru_reg[bus.req_index];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign set_tag[gi]   = tag_reg[bus.req_index][gi];
      assign match_vec[gi] = set_valid[gi] && (set_tag[gi] == bus.req_tag);
`ifdef CACHE_TAG_PARITY_EN
      // A matching tag whose stored parity disagrees is untrusted: report as miss.
      assign par_bad_vec[gi] = match_vec[gi] && (par_reg[bus.req_index][gi] != ^set_tag[gi]);
`else
      assign par_bad_vec[gi] = 1'b0;
`endif
      assign hit_vec[gi] = match_vec[gi] && !par_bad_vec[gi];
    end
  endgenerate

  assign any_hit = |hit_vec;

  always_comb begin
    hit_way   = '0;
    inv_way   = '0;
    inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_way = WW'(w);
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
  end

  generate
    if (WAYS == 4) begin : g_plru4
      assign plru_victim = set_plru[0] ? {1'b1, set_plru[2]} : {1'b0, set_plru[1]};
      always_comb begin
        plru_touch    = set_plru;
        plru_touch[0] = ~write_way[1];
        if (write_way[1]) plru_touch[2] = ~write_way[0];
        else              plru_touch[1] = ~write_way[0];
      end
    end else if (WAYS == 2) begin : g_plru2
      assign plru_victim = set_plru[0];
      assign plru_touch  = ~write_way[0];
    end else begin : g_plru1
      assign plru_victim = 1'b0;
      assign plru_touch  = set_plru;
    end
  endgenerate

  assign victim_way = inv_found ? inv_way : plru_victim;

  always_comb begin
    write_way = hit_way;
    do_touch  = 1'b0;
    case (bus.req_op)
      OP_LOOKUP: do_touch = any_hit;
      OP_FILL: begin
        if (!any_hit) write_way = victim_way;
        do_touch = 1'b1;
      end
      OP_DIRTY: do_touch = any_hit;
      default:  do_touch = 1'b0;
    endcase
  end

  // Tag/state storage. Flush and request updates never coincide: requests
  // are only accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        plru_reg[s]  <= '0;
`ifdef CACHE_TAG_PARITY_EN
        par_reg[s]   <= '0;
`endif
        for (int w = 0; w < WAYS; w++) tag_reg[s][w] <= '0;
      end
    end else if (state_reg == ST_FLUSH) begin
      valid_reg[flush_idx_reg] <= '0;
      dirty_reg[flush_idx_reg] <= '0;
      plru_reg[flush_idx_reg]  <= '0;
    end else if (accept) begin
      case (bus.req_op)
        OP_FILL: begin
          valid_reg[bus.req_index][write_way] <= 1'b1;
          dirty_reg[bus.req_index][write_way] <= 1'b0;
          tag_reg[bus.req_index][write_way]   <= bus.req_tag;
`ifdef CACHE_TAG_PARITY_EN
          par_reg[bus.req_index][write_way]   <= ^bus.req_tag;
`endif
        end
        OP_INVAL: begin
          if (any_hit) begin
            valid_reg[bus.req_index][hit_way] <= 1'b0;
            dirty_reg[bus.req_index][hit_way] <= 1'b0;
          end
        end
        OP_DIRTY: begin
          if (any_hit) dirty_reg[bus.req_index][hit_way] <= 1'b1;
        end
        default: ;
      endcase
      if (do_touch) plru_reg[bus.req_index] <= plru_touch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg        <= 1'b0;
      rsp_hit_reg          <= 1'b0;
      rsp_way_reg          <= '0;
      rsp_dirty_reg        <= 1'b0;
      rsp_victim_valid_reg <= 1'b0;
      rsp_victim_dirty_reg <= 1'b0;
      rsp_victim_tag_reg   <= '0;
`ifdef CACHE_TAG_PARITY_EN
      parity_err_reg       <= 1'b0;
`endif
    end else begin
      rsp_valid_reg <= accept;
`ifdef CACHE_TAG_PARITY_EN
      parity_err_reg <= accept && (|par_bad_vec);
`endif
      if (accept) begin
        rsp_hit_reg          <= any_hit;
        rsp_way_reg          <= write_way;
        rsp_dirty_reg        <= any_hit && set_dirty[hit_way];
        rsp_victim_valid_reg <= set_valid[victim_way];
        rsp_victim_dirty_reg <= set_dirty[victim_way];
        rsp_victim_tag_reg   <= set_tag[victim_way];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      flush_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_idx_reg <= flush_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    flush_idx_next = flush_idx_reg;
    req_ready      = 1'b0;
    flush_busy     = 1'b1;
    flush_done     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready  = 1'b1;
        flush_busy = 1'b0;
        if (bus.flush_start) begin
          state_next     = ST_FLUSH;
          flush_idx_next = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_idx_reg == IW'(SETS - 1)) state_next = ST_DONE;
        else flush_idx_next = flush_idx_reg + 1'b1;
      end
      ST_DONE: begin
        flush_done = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.req_ready        = req_ready;
  assign bus.flush_busy       = flush_busy;
  assign bus.flush_done       = flush_done;
  assign bus.rsp_valid        = rsp_valid_reg;
  assign bus.rsp_hit          = rsp_hit_reg;
  assign bus.rsp_way          = rsp_way_reg;
  assign bus.rsp_dirty        = rsp_dirty_reg;
  assign bus.rsp_victim_valid = rsp_victim_valid_reg;
  assign bus.rsp_victim_dirty = rsp_victim_dirty_reg;
  assign bus.rsp_victim_tag   = rsp_victim_tag_reg;
`ifdef CACHE_TAG_PARITY_EN
  assign bus.parity_err       = parity_err_reg;
`else
  assign bus.parity_err       = 1'b0;
`endif
endmodule
